// File: rtl/rle_pkg.sv
// Shared types and geometry for the run-length blob tracker.
package rle_pkg;

  localparam int unsigned IMAGE_W = 25;
  localparam int unsigned IMAGE_H = 20;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned RUN_W   = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t top;
    coord_t bottom;
    coord_t left;
    coord_t right;
    coord_t count;
  } blob_t;

  localparam int unsigned BLOB_W = $bits(blob_t);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic coord_t cmin(coord_t a, coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t cmax(coord_t a, coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rle_blob_accum.sv
// Candidate blob accumulator: grows a vertical stack of hit lines and
// strobes `close` with the finished record when the stack ends or the frame ends.
module rle_blob_accum
  import rle_pkg::*;
(
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                line_valid,
  input  logic                hit,
  input  logic                last_line,
  input  logic [COORD_W-1:0]  y,
  input  logic [COORD_W-1:0]  x_start,
  input  logic [COORD_W-1:0]  x_end,
  output logic                close,
  output logic                load,
  output logic [BLOB_W-1:0]   close_rec
);

  state_t state_q, state_d;
  blob_t  cand_q, cand_d, ext, rec;

  always_ff @(posedge CLK) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (line_valid) begin
      if (last_line) state_d = IDLE;
      else           state_d = hit ? RUN : IDLE;
    end
  end

  // On the frame-end line the current line is folded in before the close,
  // so the closing record is the extended candidate whenever that line hits.
  always_comb begin
    ext = '{top: y, bottom: y, left: x_start, right: x_end, count: COORD_W'(1)};
    if (state_q == RUN) begin
      ext.top   = cand_q.top;
      ext.left  = cmin(cand_q.left, x_start);
      ext.right = cmax(cand_q.right, x_end);
      ext.count = cand_q.count + COORD_W'(1);
    end
    cand_d = cand_q;
    rec    = cand_q;
    close  = 1'b0;
    load   = line_valid && last_line;
    if (line_valid) begin
      if (hit) begin
        cand_d = ext;
        rec    = ext;
      end
      close = ((state_q == RUN) && !hit) || (last_line && (hit || (state_q == RUN)));
      if (last_line) cand_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) cand_q <= '0;
    else          cand_q <= cand_d;
  end

  assign close_rec = rec;

endmodule

// File: rtl/rle_blob_tracker.sv
// Frame-level tallest-blob finder over per-line run summaries, with a
// valid/ready result register that flags overwritten results.
module rle_blob_tracker
  import rle_pkg::*;
#(
  parameter int unsigned IMAGE_W   = rle_pkg::IMAGE_W,
  parameter int unsigned IMAGE_H   = rle_pkg::IMAGE_H,
  parameter int unsigned MIN_RUN   = 3,
  parameter int unsigned MIN_LINES = 2
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic [RUN_W-1:0]   stream1,
  input  logic [RUN_W-1:0]   stream2,
  input  logic [RUN_W-1:0]   stream3,
  input  logic               im_end,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               found,
  output logic [COORD_W-1:0] box_left,
  output logic [COORD_W-1:0] box_right,
  output logic [COORD_W-1:0] box_top,
  output logic [COORD_W-1:0] box_bottom,
  output logic [COORD_W-1:0] centre_x,
  output logic [COORD_W-1:0] blob_lines,
  output logic               overrun
);

  logic [COORD_W-1:0] y;
  logic [11:0]        line_sum;
  logic               hit, last_line, close, load;
  logic [COORD_W-1:0] x_start, x_end, centre;
  logic [BLOB_W-1:0]  close_bits;
  blob_t              close_rec, best_q, best_next;

  assign line_sum  = 12'(stream1) + 12'(stream2) + 12'(stream3);
  assign hit       = (stream2 >= RUN_W'(MIN_RUN)) && (line_sum <= 12'(IMAGE_W));
  assign x_start   = COORD_W'(stream1);
  assign x_end     = COORD_W'(stream1) + COORD_W'(stream2) - COORD_W'(1);
  assign last_line = (y == COORD_W'(IMAGE_H - 1));

  always_ff @(posedge CLK) begin
    if (!reset_n)    y <= '0;
    else if (im_end) y <= last_line ? '0 : y + COORD_W'(1);
  end

  rle_blob_accum u_accum (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .line_valid (im_end),
    .hit        (hit),
    .last_line  (last_line),
    .y          (y),
    .x_start    (x_start),
    .x_end      (x_end),
    .close      (close),
    .load       (load),
    .close_rec  (close_bits)
  );

  assign close_rec = blob_t'(close_bits);

  // Strictly-greater compare keeps the earlier blob on a height tie.
  always_comb begin
    best_next = best_q;
    if (close && (close_rec.count >= COORD_W'(MIN_LINES)) && (close_rec.count > best_q.count))
      best_next = close_rec;
  end

  always_ff @(posedge CLK) begin
    if (!reset_n || load) best_q <= '0;
    else                  best_q <= best_next;
  end

  assign centre = COORD_W'(((COORD_W+1)'(best_next.left) + (COORD_W+1)'(best_next.right)) >> 1);

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      found      <= 1'b0;
      box_left   <= '0;
      box_right  <= '0;
      box_top    <= '0;
      box_bottom <= '0;
      centre_x   <= '0;
      blob_lines <= '0;
      overrun    <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      overrun    <= out_valid && !out_ready;
      found      <= (best_next.count != '0);
      box_left   <= best_next.left;
      box_right  <= best_next.right;
      box_top    <= best_next.top;
      box_bottom <= best_next.bottom;
      centre_x   <= centre;
      blob_lines <= best_next.count;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rle_blob_tracker.sv
// Directed bench for rle_blob_tracker with a frame-level reference model.
module tb_rle_blob_tracker;

  localparam int W = 25, H = 20, MINR = 3, MINL = 2;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  stream1 = '0, stream2 = '0, stream3 = '0;
  logic        im_end = 1'b0, out_ready = 1'b1;
  logic        out_valid, found, overrun;
  logic [10:0] box_left, box_right, box_top, box_bottom, centre_x, blob_lines;

  always #5 CLK = ~CLK;

  rle_blob_tracker #(.IMAGE_W(W), .IMAGE_H(H), .MIN_RUN(MINR), .MIN_LINES(MINL)) dut (
    .CLK(CLK), .reset_n(reset_n), .stream1(stream1), .stream2(stream2), .stream3(stream3),
    .im_end(im_end), .out_ready(out_ready), .out_valid(out_valid), .found(found),
    .box_left(box_left), .box_right(box_right), .box_top(box_top), .box_bottom(box_bottom),
    .centre_x(centre_x), .blob_lines(blob_lines), .overrun(overrun)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers each line of the frame, then finds the tallest stack at frame end.
  bit m_hit[H];
  int m_x0[H], m_x1[H];
  int m_y = 0;
  bit e_valid = 0, e_found = 0, e_ovr = 0, m_acc;
  int e_left = 0, e_right = 0, e_top = 0, e_bottom = 0, e_centre = 0, e_lines = 0;

  function automatic void frame_best(output int top, output int bottom, output int left,
                                     output int right, output int lines);
    int s = 0, l = 0, r = 0, n = 0;
    top = 0; bottom = 0; left = 0; right = 0; lines = 0;
    for (int i = 0; i < H; i++) begin
      if (m_hit[i]) begin
        if (n == 0) begin s = i; l = m_x0[i]; r = m_x1[i]; end
        else begin
          if (m_x0[i] < l) l = m_x0[i];
          if (m_x1[i] > r) r = m_x1[i];
        end
        n++;
        if (n >= MINL && n > lines) begin
          top = s; bottom = i; left = l; right = r; lines = n;
        end
      end else n = 0;
    end
  endfunction

  always @(posedge CLK) begin
    if (!reset_n) begin
      m_y = 0; e_valid = 0; e_found = 0; e_ovr = 0;
      e_left = 0; e_right = 0; e_top = 0; e_bottom = 0; e_centre = 0; e_lines = 0;
    end else begin
      m_acc = e_valid && out_ready;
      if (im_end) begin
        m_hit[m_y] = (int'(stream2) >= MINR) && (int'(stream1) + int'(stream2) + int'(stream3) <= W);
        m_x0[m_y]  = int'(stream1);
        m_x1[m_y]  = int'(stream1) + int'(stream2) - 1;
        if (m_y == H - 1) begin
          frame_best(e_top, e_bottom, e_left, e_right, e_lines);
          e_found  = (e_lines != 0);
          e_centre = (e_left + e_right) / 2;
          e_ovr    = e_valid && !out_ready;
          e_valid  = 1;
          m_y = 0;
        end else begin
          m_y++;
          if (m_acc) e_valid = 0;
        end
      end else if (m_acc) e_valid = 0;
    end
  end

  always @(negedge CLK) begin
    chk("out_valid", out_valid, e_valid);
    chk("found", found, e_found);
    chk("overrun", overrun, e_ovr);
    chk("box_left", box_left, e_left);
    chk("box_right", box_right, e_right);
    chk("box_top", box_top, e_top);
    chk("box_bottom", box_bottom, e_bottom);
    chk("centre_x", centre_x, e_centre);
    chk("blob_lines", blob_lines, e_lines);
  end

  // Frame stimulus table and drivers
  int fs1[H], fs2[H], fs3[H];

  task automatic clear_frame();
    for (int i = 0; i < H; i++) begin fs1[i] = 0; fs2[i] = 0; fs3[i] = W; end
  endtask

  task automatic set_lines(int first, int last, int a, int b, int c);
    for (int i = first; i <= last; i++) begin fs1[i] = a; fs2[i] = b; fs3[i] = c; end
  endtask

  task automatic send_lines(int n, int gap, bit accept_last);
    for (int i = 0; i < n; i++) begin
      stream1 = 10'(fs1[i]); stream2 = 10'(fs2[i]); stream3 = 10'(fs3[i]);
      im_end = 1'b1;
      if (i == n - 1 && accept_last) out_ready = 1'b1;
      @(negedge CLK);
      if (gap > 0 && i != n - 1) begin im_end = 1'b0; repeat (gap) @(negedge CLK); end
    end
    im_end = 1'b0;
    if (accept_last) out_ready = 1'b0;
  endtask

  task automatic frame_a();
    clear_frame();
    set_lines(5, 5, 10, 4, 11); set_lines(6, 6, 9, 5, 11);
    set_lines(7, 7, 10, 4, 11); set_lines(8, 8, 11, 3, 11);
  endtask

  task automatic frame_b();
    clear_frame();
    set_lines(2, 3, 4, 5, 16); set_lines(10, 14, 4, 5, 16);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_valid", out_valid, 0); chk("rst_found", found, 0); chk("rst_right", box_right, 0);
    reset_n = 1'b1;

    frame_a(); send_lines(H, 0, 0);
    chk("a_valid", out_valid, 1); chk("a_found", found, 1);
    chk("a_left", box_left, 9); chk("a_right", box_right, 13);
    chk("a_top", box_top, 5); chk("a_bottom", box_bottom, 8);
    chk("a_centre", centre_x, 11); chk("a_lines", blob_lines, 4);
    @(negedge CLK); chk("a_drop", out_valid, 0);

    frame_b(); send_lines(H, 1, 0);
    chk("b_lines", blob_lines, 5); chk("b_top", box_top, 10); chk("b_bottom", box_bottom, 14);

    clear_frame(); set_lines(2, 4, 2, 5, 18); set_lines(10, 12, 8, 5, 12);
    send_lines(H, 0, 0);
    chk("tie_top", box_top, 2); chk("tie_left", box_left, 2); chk("tie_lines", blob_lines, 3);

    clear_frame(); set_lines(7, 7, 5, 2, 18); send_lines(H, 0, 0);
    chk("short_found", found, 0); chk("short_valid", out_valid, 1);
    clear_frame(); set_lines(7, 7, 5, 6, 14); send_lines(H, 0, 0);
    chk("single_found", found, 0); chk("single_lines", blob_lines, 0); chk("single_right", box_right, 0);

    clear_frame(); set_lines(3, 10, 2, 6, 17); set_lines(6, 6, 20, 6, 5);
    send_lines(H, 0, 0);
    chk("split_top", box_top, 7); chk("split_bottom", box_bottom, 10);
    chk("split_lines", blob_lines, 4); chk("split_right", box_right, 7);

    @(negedge CLK);
    out_ready = 1'b0;
    frame_a(); send_lines(H, 0, 0);
    chk("ovr_first", overrun, 0);
    frame_b(); send_lines(H, 0, 0);
    chk("ovr_set", overrun, 1); chk("ovr_lines", blob_lines, 5);
    out_ready = 1'b1; @(negedge CLK);
    chk("ovr_drop", out_valid, 0);

    out_ready = 1'b0;
    frame_a(); send_lines(H, 0, 0);
    frame_b(); send_lines(H, 0, 1);
    chk("coin_valid", out_valid, 1); chk("coin_ovr", overrun, 0); chk("coin_lines", blob_lines, 5);
    @(negedge CLK); chk("coin_hold", out_valid, 1);
    out_ready = 1'b1; @(negedge CLK); chk("coin_drop", out_valid, 0);

    out_ready = 1'b0;
    frame_b(); send_lines(H, 0, 0);
    clear_frame(); set_lines(8, 12, 4, 5, 16); send_lines(11, 0, 0);
    reset_n = 1'b0; @(negedge CLK);
    chk("mid_valid", out_valid, 0); chk("mid_lines", blob_lines, 0); chk("mid_top", box_top, 0);
    reset_n = 1'b1; out_ready = 1'b1;
    frame_a(); send_lines(H, 0, 0);
    chk("fresh_found", found, 1); chk("fresh_top", box_top, 5); chk("fresh_lines", blob_lines, 4);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
